// File: rtl/fpnew_opgroup_result_queue.sv
// fpnew_opgroup_result_queue
//
// Result buffer placed downstream of an operation-group block. It decouples the
// arbitrated result stream from the FPU output port. Each entry holds a result,
// its IEEE status flags, the extension bit and the user tag. The storage is a
// small circular FIFO. The depth does not have to be a power of two.
//
// Sticky exception flags accumulate the status of every result that is consumed
// downstream. A flush does not touch these flags.
//
// Optional feature: define FPNEW_RESULT_QUEUE_BYPASS_EN to let a result reach
// the outputs combinationally while the queue is empty. The result skips the
// storage entirely if downstream takes it in that same cycle.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   result_i, status_i,   incoming entry fields from the opgroup block
//   extension_bit_i,
//   tag_i
//   in_valid_i/in_ready_o upstream handshake; in_ready_o has no path from out_ready_i
//   flush_i               synchronous drop of every stored entry
//   result_o, status_o,   head entry fields
//   extension_bit_o,
//   tag_o
//   out_valid_o/out_ready_i downstream handshake
//   fflags_o, fflags_clr_i sticky OR of consumed status, and its clear
//   count_o, busy_o       occupancy, and a non-empty indication for the busy tree

module fpnew_opgroup_result_queue #(
    parameter int unsigned Width    = 32,
    parameter int unsigned Depth    = 2,
    parameter type         TagType  = logic,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Width-1:0]    result_i,
    input  logic [4:0]          status_i,
    input  logic                extension_bit_i,
    input  TagType              tag_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                flush_i,
    output logic [Width-1:0]    result_o,
    output logic [4:0]          status_o,
    output logic                extension_bit_o,
    output TagType              tag_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [4:0]          fflags_o,
    input  logic                fflags_clr_i,
    output logic [CntWidth-1:0] count_o,
    output logic                busy_o
);

    localparam int unsigned      PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    logic [Width-1:0]    result_q [Depth];
    logic [4:0]          status_q [Depth];
    logic                ext_q    [Depth];
    TagType              tag_q    [Depth];

    logic [PtrWidth-1:0] wp_q, rp_q;
    logic [CntWidth-1:0] cnt_q;
    logic [4:0]          fflags_q;

    logic                empty;
    logic                push;       // entry written into storage
    logic                pop;        // stored head entry consumed
    logic                handshake;  // downstream transfer, stored or bypassed
`ifdef FPNEW_RESULT_QUEUE_BYPASS_EN
    logic                bypass;
`endif

    function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty           = (cnt_q == '0);
        in_ready_o      = (cnt_q < DepthCnt) & ~flush_i;
        out_valid_o     = ~empty & ~flush_i;
        result_o        = result_q[rp_q];
        status_o        = status_q[rp_q];
        extension_bit_o = ext_q[rp_q];
        tag_o           = tag_q[rp_q];
        pop             = ~empty & ~flush_i & out_ready_i;
        push            = in_valid_i & in_ready_o;
`ifdef FPNEW_RESULT_QUEUE_BYPASS_EN
        bypass = empty & in_valid_i & ~flush_i;
        if (bypass) begin
            out_valid_o     = 1'b1;
            result_o        = result_i;
            status_o        = status_i;
            extension_bit_o = extension_bit_i;
            tag_o           = tag_i;
        end
        // A bypassed result that is taken immediately never occupies a slot.
        if (bypass & out_ready_i) push = 1'b0;
`endif
        handshake       = out_valid_o & out_ready_i;
    end

    // The storage array is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            result_q[wp_q] <= result_i;
            status_q[wp_q] <= status_i;
            ext_q[wp_q]    <= extension_bit_i;
            tag_q[wp_q]    <= tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= ptr_next(wp_q);
            if (pop)  rp_q <= ptr_next(rp_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // The clear is applied first, so a result consumed in the clear cycle is kept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | (handshake ? status_o : 5'b0);
        end
    end

    assign fflags_o = fflags_q;
    assign count_o  = cnt_q;
    assign busy_o   = ~empty;

endmodule

// File: tb/tb_fpnew_opgroup_result_queue.sv
module tb_fpnew_opgroup_result_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Depth=2 instance
    logic [31:0] a_res_i, a_res_o;
    logic [4:0]  a_st_i, a_st_o, a_ff;
    logic        a_ext_i, a_ext_o;
    logic [3:0]  a_tag_i, a_tag_o;
    logic        a_iv, a_ir, a_fl, a_ov, a_or, a_clr, a_busy;
    logic [1:0]  a_cnt;

    // Depth=3 instance
    logic [31:0] b_res_i, b_res_o;
    logic [4:0]  b_st_o, b_ff;
    logic        b_ext_o;
    logic [3:0]  b_tag_i, b_tag_o;
    logic        b_iv, b_ir, b_ov, b_or, b_busy;
    logic [1:0]  b_cnt;

    fpnew_opgroup_result_queue #(.Width(32), .Depth(2), .TagType(logic [3:0])) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .result_i(a_res_i), .status_i(a_st_i), .extension_bit_i(a_ext_i), .tag_i(a_tag_i),
        .in_valid_i(a_iv), .in_ready_o(a_ir), .flush_i(a_fl),
        .result_o(a_res_o), .status_o(a_st_o), .extension_bit_o(a_ext_o), .tag_o(a_tag_o),
        .out_valid_o(a_ov), .out_ready_i(a_or),
        .fflags_o(a_ff), .fflags_clr_i(a_clr), .count_o(a_cnt), .busy_o(a_busy)
    );

    fpnew_opgroup_result_queue #(.Width(32), .Depth(3), .TagType(logic [3:0])) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .result_i(b_res_i), .status_i(5'h00), .extension_bit_i(1'b0), .tag_i(b_tag_i),
        .in_valid_i(b_iv), .in_ready_o(b_ir), .flush_i(1'b0),
        .result_o(b_res_o), .status_o(b_st_o), .extension_bit_o(b_ext_o), .tag_o(b_tag_o),
        .out_valid_o(b_ov), .out_ready_i(b_or),
        .fflags_o(b_ff), .fflags_clr_i(1'b0), .count_o(b_cnt), .busy_o(b_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] r, input logic [4:0] s,
                           input logic e, input logic [3:0] t);
        a_iv = v; a_res_i = r; a_st_i = s; a_ext_i = e; a_tag_i = t;
    endtask

    int          sent, recv;
    logic        b_push;
    logic [19:0] rdy_pat;

    initial begin
        rst_n = 1'b0;
        drive_a(1'b0, 32'h0, 5'h0, 1'b0, 4'h0);
        a_fl = 1'b0; a_or = 1'b0; a_clr = 1'b0;
        b_iv = 1'b0; b_res_i = '0; b_tag_i = '0; b_or = 1'b0;
        #1;
        check("rst_count", 32'(a_cnt), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_out_valid", 32'(a_ov), 0);
        check("rst_in_ready", 32'(a_ir), 1);
        check("rst_fflags", 32'(a_ff), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First push, downstream stalled
        drive_a(1'b1, 32'h3F800000, 5'h01, 1'b1, 4'h1);
        #1;
`ifdef FPNEW_RESULT_QUEUE_BYPASS_EN
        check("first_bypass_valid", 32'(a_ov), 1);
`else
        check("first_no_comb_valid", 32'(a_ov), 0);
`endif
        tick();
        drive_a(1'b0, 32'h0, 5'h0, 1'b0, 4'h0);
        #1;
        check("first_valid", 32'(a_ov), 1);
        check("first_result", a_res_o, 32'h3F800000);
        check("first_tag", 32'(a_tag_o), 1);
        check("first_ext", 32'(a_ext_o), 1);
        check("first_count", 32'(a_cnt), 1);
        check("first_busy", 32'(a_busy), 1);

        // Fill to full, then try to push while popping
        drive_a(1'b1, 32'h22222222, 5'h10, 1'b0, 4'h2);
        tick();
        drive_a(1'b1, 32'h33333333, 5'h04, 1'b0, 4'h3);
        #1;
        check("full_in_ready", 32'(a_ir), 0);
        check("full_count", 32'(a_cnt), 2);
        a_or = 1'b1;
        #1;
        check("full_pop_no_ready", 32'(a_ir), 0);
        check("full_head_A", a_res_o, 32'h3F800000);
        tick();
        a_or = 1'b0;
        #1;
        check("after_popA_count", 32'(a_cnt), 1);
        check("after_popA_fflags", 32'(a_ff), 32'h01);
        check("after_popA_head_B", a_res_o, 32'h22222222);
        check("after_popA_in_ready", 32'(a_ir), 1);
        tick();
        drive_a(1'b0, 32'h0, 5'h0, 1'b0, 4'h0);
        a_or = 1'b1;
        #1;
        check("C_accepted_count", 32'(a_cnt), 2);
        check("order_B", a_res_o, 32'h22222222);
        check("order_B_tag", 32'(a_tag_o), 2);
        tick();
        check("order_C", a_res_o, 32'h33333333);
        check("order_C_tag", 32'(a_tag_o), 3);
        check("mid_fflags", 32'(a_ff), 32'h11);
        tick();
        a_or = 1'b0;
        #1;
        check("drained_count", 32'(a_cnt), 0);
        check("drained_valid", 32'(a_ov), 0);
        check("drained_fflags", 32'(a_ff), 32'h15);

        // Sticky flags and clear
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        #1;
        check("clr_fflags", 32'(a_ff), 0);
        drive_a(1'b1, 32'hD0D0D0D0, 5'h10, 1'b0, 4'h4);
        tick();
        drive_a(1'b1, 32'hE0E0E0E0, 5'h04, 1'b0, 4'h5);
        tick();
        drive_a(1'b0, 32'h0, 5'h0, 1'b0, 4'h0);
        a_or = 1'b1;
        tick();
        check("sticky_first", 32'(a_ff), 32'h10);
        tick();
        check("sticky_both", 32'(a_ff), 32'h14);
        a_or = 1'b0;
        drive_a(1'b1, 32'hF0F0F0F0, 5'h01, 1'b0, 4'h6);
        tick();
        drive_a(1'b0, 32'h0, 5'h0, 1'b0, 4'h0);
        a_or = 1'b1; a_clr = 1'b1;
        tick();
        a_or = 1'b0; a_clr = 1'b0;
        #1;
        check("clr_with_pop", 32'(a_ff), 32'h01);
        check("clr_with_pop_count", 32'(a_cnt), 0);

        // Flush with two entries and a simultaneous push
        drive_a(1'b1, 32'h66666666, 5'h08, 1'b0, 4'h7);
        tick();
        drive_a(1'b1, 32'h77777777, 5'h02, 1'b0, 4'h8);
        tick();
        check("pre_flush_count", 32'(a_cnt), 2);
        drive_a(1'b1, 32'h88888888, 5'h10, 1'b0, 4'h9);
        a_fl = 1'b1; a_or = 1'b1;
        #1;
        check("flush_in_ready", 32'(a_ir), 0);
        check("flush_out_valid", 32'(a_ov), 0);
        tick();
        a_fl = 1'b0; a_or = 1'b0;
        drive_a(1'b0, 32'h0, 5'h0, 1'b0, 4'h0);
        #1;
        check("post_flush_count", 32'(a_cnt), 0);
        check("post_flush_valid", 32'(a_ov), 0);
        check("post_flush_fflags", 32'(a_ff), 32'h01);
        drive_a(1'b1, 32'h4A4A4A4A, 5'h00, 1'b0, 4'hA);
        tick();
        drive_a(1'b0, 32'h0, 5'h0, 1'b0, 4'h0);
        #1;
        check("post_flush_head", a_res_o, 32'h4A4A4A4A);
        check("post_flush_head_count", 32'(a_cnt), 1);
        a_or = 1'b1;
        tick();
        a_or = 1'b0;
        #1;
        check("post_flush_empty", 32'(a_cnt), 0);

        // Empty queue, valid input with downstream ready
        drive_a(1'b1, 32'h40000000, 5'h02, 1'b0, 4'hB);
        a_or = 1'b1;
        #1;
`ifdef FPNEW_RESULT_QUEUE_BYPASS_EN
        check("bypass_valid", 32'(a_ov), 1);
        check("bypass_result", a_res_o, 32'h40000000);
        check("bypass_count", 32'(a_cnt), 0);
        tick();
        drive_a(1'b0, 32'h0, 5'h0, 1'b0, 4'h0);
        a_or = 1'b0;
        #1;
        check("bypass_count_after", 32'(a_cnt), 0);
        check("bypass_fflags", 32'(a_ff), 32'h03);
`else
        check("nobypass_valid", 32'(a_ov), 0);
        tick();
        drive_a(1'b0, 32'h0, 5'h0, 1'b0, 4'h0);
        #1;
        check("nobypass_count", 32'(a_cnt), 1);
        check("nobypass_result", a_res_o, 32'h40000000);
        tick();
        a_or = 1'b0;
        #1;
        check("nobypass_fflags", 32'(a_ff), 32'h03);
        check("nobypass_drained", 32'(a_cnt), 0);
`endif

        // Reset mid-operation
        drive_a(1'b1, 32'h12345678, 5'h1F, 1'b0, 4'hC);
        tick();
        drive_a(1'b0, 32'h0, 5'h0, 1'b0, 4'h0);
        a_or = 1'b1;
        tick();
        a_or = 1'b0;
        check("pre_reset_fflags", 32'(a_ff), 32'h1F);
        rst_n = 1'b0;
        #1;
        check("async_reset_fflags", 32'(a_ff), 0);
        check("async_reset_count", 32'(a_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap-around on the Depth=3 instance
        rdy_pat = 20'b1111_0110_1011_0100_0000;
        sent = 0;
        recv = 0;
        for (int c = 0; c < 80 && recv < 10; c++) begin
            b_iv    = (sent < 10);
            b_res_i = 32'(sent);
            b_tag_i = 4'(sent);
            b_or    = (c < 20) ? rdy_pat[c] : 1'b1;
            #1;
            b_push = b_iv & b_ir;
            if (b_ov && b_or) begin
                check("wrap_data", b_res_o, 32'(recv));
                check("wrap_tag", 32'(b_tag_o), 32'(recv % 16));
                recv++;
            end
            tick();
            if (b_push) sent++;
        end
        b_iv = 1'b0;
        b_or = 1'b0;
        #1;
        check("wrap_received", 32'(recv), 10);
        check("wrap_final_count", 32'(b_cnt), 0);
        check("wrap_final_busy", 32'(b_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpnew_opgroup_result_queue.md
# fpnew_opgroup_result_queue

Result buffer that sits directly downstream of an operation-group block and decouples its arbitrated result stream from the FPU output port. Captures result, status, extension bit and tag into a small circular FIFO. Accumulates sticky IEEE exception flags for every result consumed downstream. Reports occupancy and busy for the FPU-level busy tree.

## Interface
Parameters:
- Width, 32, result width in bits
- Depth, 2, FIFO entries; legal range 1..16
- TagType, logic, user tag type carried with each result
- CntWidth (localparam), $clog2(Depth+1), occupancy counter width

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- result_i  input  Width  result from the opgroup block
- status_i  input  fpnew_pkg::status_t (5)  {NV,DZ,OF,UF,NX}
- extension_bit_i  input  1  extension bit
- tag_i  input  TagType  tag
- in_valid_i  input  1  upstream valid
- in_ready_o  output  1  queue accepts an entry
- flush_i  input  1  synchronous drop of all entries
- result_o  output  Width  head result
- status_o  output  5  head status
- extension_bit_o  output  1  head extension bit
- tag_o  output  TagType  head tag
- out_valid_o  output  1  head valid
- out_ready_i  input  1  downstream ready
- fflags_o  output  5  sticky OR of status of every popped result
- fflags_clr_i  input  1  clear sticky flags
- count_o  output  CntWidth  current occupancy
- busy_o  output  1  queue holds data

## Operation
- Storage: Depth-entry array, write pointer wp, read pointer rp, counter cnt. Pointers wrap from Depth-1 to 0; no power-of-two requirement.
- Push = in_valid_i & in_ready_o: entry[wp] <= inputs; wp advances.
- Pop = out_valid_o & out_ready_i: rp advances.
- cnt: +1 on push only, -1 on pop only, unchanged on both or neither.
- in_ready_o = (cnt < Depth) & ~flush_i. No combinational path from out_ready_i, so a full queue does not accept a push, even when a pop occurs in the same cycle.
- out_valid_o = (cnt != 0) & ~flush_i. Data outputs always show entry[rp]. Contents are don't-care when empty.
- Flush: on the next edge wp, rp and cnt become 0. Any push or pop in the flush cycle is ignored. fflags_o is NOT affected by flush.
- Sticky flags: on the next edge, fflags_o becomes (fflags_clr_i ? 0 : fflags_o) | (pop ? status_o : 0). A pop in the same cycle as a clear survives the clear.
- busy_o = (cnt != 0).
- count_o = cnt.

## Timing
- Reset values: cnt, wp, rp = 0; fflags_o = 0; out_valid_o = 0; busy_o = 0; count_o = 0; in_ready_o = 1 (flush_i low). Storage array is not reset.
- Latency without bypass: a push at edge N makes out_valid_o high after edge N (visible in cycle N+1). Minimum latency is 1 cycle.
- Throughput: 1 result/cycle while 0 < cnt < Depth. With Depth=1 and no bypass, throughput is 1 result per 2 cycles.
- Handshake: once out_valid_o is high, the head entry stays stable until it is popped or flushed. in_ready_o may drop only because of occupancy or flush.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). Entries are lost.

## Configuration
- FPNEW_RESULT_QUEUE_BYPASS_EN defined:
  - When cnt==0, in_valid_i=1 and flush_i=0, out_valid_o=1 and outputs show the input fields combinationally.
  - If out_ready_i=1 in that cycle, the result passes through without being written; cnt, wp and rp are unchanged; fflags updates with status_i.
  - If out_ready_i=0, the entry is written normally.
  - Latency is 0 cycles when empty.
- Undefined: no combinational path from inputs to outputs. Latency is exactly as described under Timing.

## Test plan
- Reset, Depth=2: push result 0x3F800000 tag 1 status 0x01, out_ready_i=0 -> next cycle out_valid_o=1, result_o=0x3F800000, count_o=1, busy_o=1.
- Fill to full: push A, B with out_ready_i=0 -> in_ready_o=0 and count_o=2. Hold in_valid_i with C while popping A -> C is not accepted that cycle. Next cycle C is accepted; order is A, B, C.
- Wrap-around, Depth=3: 10 pushes with random out_ready_i -> outputs in order 0..9 with matching tags, no loss or duplication.
- Flush with count_o=2 and simultaneous push -> next cycle count_o=0, out_valid_o=0; the pushed entry never appears; fflags_o unchanged.
- Sticky flags: pop status 0x10 then 0x04 -> fflags_o=0x14. Pop status 0x01 together with fflags_clr_i=1 -> fflags_o=0x01.
- Bypass (macro defined): empty queue, in_valid_i=1, out_ready_i=1, result 0x40000000 -> out_valid_o=1 in the same cycle with result_o=0x40000000; count_o stays 0.
